// File: rtl/decoder_nto2n_scan.sv
// decoder_nto2n_scan: N-to-2**N one-hot decoder with an optional auto-scan mode.
// Direct mode decodes sel on each valid/ready transfer with one cycle of latency.
// Scan mode (present only when DEC_SCAN_EN is defined) steps through the indices.
// Each index is held for DWELL cycles, and wrap pulses on each wrap-around.
// Without DEC_SCAN_EN, mode is ignored and wrap is tied low.
module decoder_nto2n_scan #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     sel,
  output logic [2**N-1:0]  O,
  output logic             out_valid,
  output logic [N-1:0]     idx,
  output logic             wrap
);

  localparam int W = 2**N;

`ifdef DEC_SCAN_EN
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  logic          mode_eff;
  logic [CW-1:0] cnt;

  assign mode_eff = mode;
`else
  typedef enum logic [1:0] {IDLE, DIRECT} state_t;

  logic mode_eff;
  logic mode_unused;

  assign mode_eff    = 1'b0;
  assign mode_unused = mode;
  assign wrap        = 1'b0;
`endif

  state_t state;
  state_t next_state;
  logic   transfer;

  function automatic logic [W-1:0] decode(input logic [N-1:0] i);
    decode    = '0;
    decode[i] = 1'b1;
  endfunction

  assign in_ready = en & ~mode_eff;
  assign transfer = in_valid & in_ready;

  // State register; reset returns the FSM to IDLE immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state depends only on en and mode, never on the current state
  always_comb begin
    next_state = IDLE;
    if (en) begin
`ifdef DEC_SCAN_EN
      if (mode_eff) next_state = SCAN;
      else          next_state = DIRECT;
`else
      next_state = DIRECT;
`endif
    end
  end

`ifdef DEC_SCAN_EN
  // Output and dwell registers, keyed on the state being entered on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O         <= '0;
      out_valid <= 1'b0;
      idx       <= '0;
      wrap      <= 1'b0;
      cnt       <= '0;
    end else begin
      wrap <= 1'b0;
      case (next_state)
        DIRECT: begin
          cnt <= '0;
          if (transfer) begin
            O         <= decode(sel);
            idx       <= sel;
            out_valid <= 1'b1;
          end else if (state != DIRECT) begin
            O         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (state != SCAN) begin
            O         <= decode('0);
            idx       <= '0;
            out_valid <= 1'b1;
            cnt       <= '0;
          end else if (cnt == CW'(DWELL - 1)) begin
            cnt       <= '0;
            idx       <= idx + N'(1);
            O         <= decode(idx + N'(1));
            out_valid <= 1'b1;
            wrap      <= (idx == N'(W - 1));
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          O         <= '0;
          out_valid <= 1'b0;
          idx       <= '0;
          cnt       <= '0;
        end
      endcase
    end
  end
`else
  // Output registers for the direct-only build
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O         <= '0;
      out_valid <= 1'b0;
      idx       <= '0;
    end else begin
      case (next_state)
        DIRECT: begin
          if (transfer) begin
            O         <= decode(sel);
            idx       <= sel;
            out_valid <= 1'b1;
          end else if (state != DIRECT) begin
            O         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          O         <= '0;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// tb_decoder_nto2n_scan: scoreboard bench for decoder_nto2n_scan (N=3, DWELL=4).
// Expectations follow DEC_SCAN_EN when it is defined for the build.
module tb_decoder_nto2n_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] O;
  logic       out_valid;
  logic [2:0] idx;
  logic       wrap;

  typedef struct {
    string      name;
    logic [7:0] o;
    logic       v;
    logic [2:0] i;
    logic       w;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  decoder_nto2n_scan #(.N(3), .DWELL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .O         (O),
    .out_valid (out_valid),
    .idx       (idx),
    .wrap      (wrap)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check in_ready, and queue the response due after the next edge
  task automatic apply_stimulus(input string name, input logic e, input logic m, input logic iv,
                                input logic [2:0] s, input logic exp_rdy,
                                input logic [7:0] eo, input logic ev, input logic [2:0] ei,
                                input logic ew);
    exp_t t;
    @(negedge clk);
    en = e; mode = m; in_valid = iv; sel = s;
    t.name = name; t.o = eo; t.v = ev; t.i = ei; t.w = ew;
    q.push_back(t);
    #1;
    check_output({name, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
  endtask

  // One scan cycle, c counted from 1 at the entry edge
  task automatic scan_cycle(input string name, input int c);
    int         k;
    logic [2:0] ei;
    logic       ew;
    k  = ((c - 1) / 4) % 8;
    ei = 3'(k);
    ew = (c > 1) && (((c - 1) % 32) == 0);
    apply_stimulus(name, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'(1 << k), 1'b1, ei, ew);
  endtask

  // Monitor: pop and compare one expectation shortly after each rising edge
  initial begin
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        t = q.pop_front();
        check_output({t.name, "_O"},    32'(O),         32'(t.o));
        check_output({t.name, "_vld"},  32'(out_valid), 32'(t.v));
        check_output({t.name, "_idx"},  32'(idx),       32'(t.i));
        check_output({t.name, "_wrap"}, 32'(wrap),      32'(t.w));
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = '0;
    #1;
    check_output("rst_O",    32'(O),         32'h0);
    check_output("rst_vld",  32'(out_valid), 32'h0);
    check_output("rst_idx",  32'(idx),       32'h0);
    check_output("rst_wrap", 32'(wrap),      32'h0);
    check_output("rst_rdy",  32'(in_ready),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back direct decodes of 0..7
    for (int s = 0; s < 8; s++)
      apply_stimulus("direct", 1'b1, 1'b0, 1'b1, 3'(s), 1'b1, 8'(1 << s), 1'b1, 3'(s), 1'b0);

    // Hold with no transfer, then disable
    apply_stimulus("hold", 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h80, 1'b1, 3'd7, 1'b0);
    apply_stimulus("hold", 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h80, 1'b1, 3'd7, 1'b0);
    apply_stimulus("idle", 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    apply_stimulus("idle", 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    apply_stimulus("d6",   1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 3'd6, 1'b0);

    // Asynchronous reset in the middle of the high phase
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("arst_O",   32'(O),         32'h0);
    check_output("arst_vld", 32'(out_valid), 32'h0);
    check_output("arst_idx", 32'(idx),       32'h0);
    en = 1'b1; mode = 1'b1; in_valid = 1'b0; sel = 3'd6;

`ifdef DEC_SCAN_EN
    begin
      exp_t t;
      @(negedge clk);
      rst_n = 1'b1;
      t.name = "scan"; t.o = 8'h01; t.v = 1'b1; t.i = 3'd0; t.w = 1'b0;
      q.push_back(t);
      #1;
      check_output("rel_rdy", 32'(in_ready), 32'h0);
    end
    for (int c = 2; c <= 40; c++) scan_cycle("scan", c);

    // Drop en for a cycle, rescan up to idx 5, drop en again and re-enter
    apply_stimulus("off", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    for (int c = 1; c <= 21; c++) scan_cycle("scan2", c);
    apply_stimulus("off5", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    for (int c = 1; c <= 5; c++) scan_cycle("rescan", c);

    // Switch to direct with a transfer, then back to scan while in_valid is high
    apply_stimulus("to_dir", 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0);
    apply_stimulus("msw",    1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0);
    apply_stimulus("msw2",   1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0);
`else
    begin
      exp_t t;
      @(negedge clk);
      rst_n = 1'b1;
      t.name = "nscan_rel"; t.o = 8'h00; t.v = 1'b0; t.i = 3'd0; t.w = 1'b0;
      q.push_back(t);
      #1;
      check_output("rel_rdy", 32'(in_ready), 32'h1);
    end
    // mode is ignored: sel=6 is accepted and held, wrap never rises
    apply_stimulus("nscan6", 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 3'd6, 1'b0);
    for (int c = 0; c < 40; c++)
      apply_stimulus("nscan_hold", 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 8'h40, 1'b1, 3'd6, 1'b0);
    apply_stimulus("nscan3", 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0);
`endif

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_scan.md
DECODER_NTO2N_SCAN -- requirements
Module: decoder_nto2n_scan

Interface
REQ-001 The block SHALL have parameter N, default 3, select width; output width is 2**N; legal range 1..6.
REQ-002 The block SHALL have parameter DWELL, default 4, cycles each index is held in scan mode; legal range 1..256.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 The block SHALL have port en  input  1  global enable; 0 forces IDLE.
REQ-006 The block SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port in_valid  input  1  sel is valid this cycle.
REQ-008 The block SHALL have port in_ready  output  1  block accepts sel this cycle; combinational from state, en and mode.
REQ-009 The block SHALL have port sel  input  N  index to decode.
REQ-010 The block SHALL have port O  output  2**N  registered one-hot (or all-zero) decode.
REQ-011 The block SHALL have port out_valid  output  1  O holds a valid one-hot value.
REQ-012 The block SHALL have port idx  output  N  index currently driven on O.
REQ-013 The block SHALL have port wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-014 The FSM SHALL have states IDLE, DIRECT and SCAN, evaluated each cycle from en and mode: en=0 -> IDLE; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
REQ-015 In IDLE, O SHALL be 0, out_valid 0, idx 0, wrap 0, in_ready 0 and the dwell counter 0, all registered one cycle after en falls.
REQ-016 in_ready SHALL be 1 exactly when en=1 and mode=0, including the cycle the FSM enters DIRECT.
REQ-017 A transfer occurs when in_valid=1 and in_ready=1; on the next edge O SHALL be 1<<sel, idx SHALL be sel and out_valid SHALL be 1 (latency 1 cycle).
REQ-018 In DIRECT, O, idx and out_valid SHALL hold their values until the next transfer or a state change; back-to-back transfers every cycle SHALL be supported.
REQ-019 On any state change (IDLE<->DIRECT<->SCAN), O SHALL be cleared and out_valid deasserted on that edge unless a new value is loaded on the same edge per REQ-017 or REQ-020.
REQ-020 On entry to SCAN, the next edge SHALL load idx=0, O=1, out_valid=1 and reset the dwell counter to 0.
REQ-021 In SCAN, the dwell counter SHALL increment each cycle; when it reaches DWELL-1 it SHALL return to 0 and idx SHALL advance by 1, with O=1<<idx, so each index is held exactly DWELL cycles.
REQ-022 When idx=2**N-1 advances, idx SHALL wrap to 0 and wrap SHALL be 1 for exactly the cycle in which O=1 is first driven again; otherwise wrap SHALL be 0.
REQ-023 With DWELL=1, idx SHALL advance every cycle and wrap SHALL pulse once every 2**N cycles.
REQ-024 In SCAN, in_valid and sel SHALL be ignored; in_ready SHALL be 0.
REQ-025 O SHALL never have more than one bit set in any cycle.

Reset
REQ-026 While rst_n=0, O, out_valid, idx, wrap and the dwell counter SHALL be 0 and the FSM SHALL be in IDLE, immediately and independent of clk.
REQ-027 Reset asserted mid-scan or mid-transfer SHALL discard the operation; after rst_n rises the FSM SHALL re-evaluate en and mode on the first edge per REQ-014, and SCAN SHALL restart at idx 0.

Configuration
REQ-028 Macro DEC_SCAN_EN defined: SCAN state, dwell counter and wrap logic SHALL be present per REQ-020..REQ-024.
REQ-029 Macro DEC_SCAN_EN undefined: mode SHALL be ignored (treated as 0), the SCAN state and dwell counter SHALL be absent and wrap SHALL be tied to 0.

Verification (N=3, DWELL=4, DEC_SCAN_EN defined unless noted)
REQ-030 en=1, mode=0, sel=0..7 with in_valid=1 every cycle -> each cycle O=8'h01,8'h02,...,8'h80 one cycle after its sel; out_valid=1; in_ready=1 throughout.
REQ-031 en=1, mode=1 for 40 cycles -> O=8'h01 for 4 cycles, then 8'h02, ... 8'h80; wrap=1 only on the cycle O returns to 8'h01 (cycle 33 after entry).
REQ-032 Scan at idx=5, drop en for 1 cycle, then raise it -> O=0 and out_valid=0 next edge; after re-entry scan restarts at O=8'h01 with dwell counter 0.
REQ-033 Assert rst_n=0 mid-clock while in DIRECT with O=8'h40 -> O=0, out_valid=0 immediately; release rst_n with mode=1 -> O=8'h01 on first edge.
REQ-034 DIRECT with sel=3 and in_valid=1, switch mode to 1 the same cycle -> no transfer, next edge O=8'h01 (SCAN entry); in_ready=0 while mode=1.
REQ-035 DEC_SCAN_EN undefined, mode=1, sel=6 accepted -> O=8'h40; wrap stays 0 for all cycles.
